// File: rtl/ps2_host_receiver_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ps2_host_receiver_pkg
//  Description : Shared types and default constants for the PS/2 host
//                receive path: pin bundle, receive strobe record, receiver
//                FSM encoding and default timeout/inhibit tick counts.
//  Revision    : 1.0 - initial release
// ============================================================================
package ps2_host_receiver_pkg;

   // ~120 us and ~100 us at a 3 us tick
   localparam int TIMEOUT_TICKS_DEFAULT = 40;
   localparam int INHIBIT_TICKS_DEFAULT = 34;

   // Width of the shared timeout/inhibit tick counter (holds values up to 255)
   localparam int CNT_W = 8;

   typedef struct packed {
      logic clk;
      logic data;
   } t_ps2_pins;

   typedef struct packed {
      logic       valid;
      logic [7:0] data;
      logic       parity_error;
      logic       protocol_error;
      logic       timeout;
   } t_ps2_rx_data;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_DATA    = 3'd1,
      ST_PARITY  = 3'd2,
      ST_STOP    = 3'd3,
      ST_INHIBIT = 3'd4
   } t_ps2_rx_fsm;

endpackage
`default_nettype wire

// File: rtl/ps2_host_receiver_clock_sampler.sv
`default_nettype none
// ============================================================================
//  Module      : ps2_clock_sampler
//  Description : Two-flop synchroniser on the PS/2 pins, programmable tick
//                divider and tick-rate glitch filter on the PS/2 clock.
//  Ports       : clk, clk__enable, reset (async, active high)
//                divider_i      - clk cycles per tick minus 1; 0 = no ticks
//                pins_i         - raw PS/2 clock/data pins
//                tick_o         - one-cycle tick strobe
//                falling_edge_o - filtered clock went 1->0 on this tick
//                sampled_data_o - synchronised data pin
//  Revision    : 1.0 - initial release
// ============================================================================
module ps2_clock_sampler
   import ps2_host_receiver_pkg::*;
(
   input  logic        clk,
   input  logic        clk__enable,
   input  logic        reset,
   input  logic [15:0] divider_i,
   input  t_ps2_pins   pins_i,
   output logic        tick_o,
   output logic        falling_edge_o,
   output logic        sampled_data_o
);

   t_ps2_pins   meta_q;
   t_ps2_pins   sync_q;
   logic [15:0] tick_cnt_q, tick_cnt_d;
   logic        clk_smp_q;     // previous tick's clock sample
   logic        filt_clk_q, filt_clk_d;

   // >= rather than == so a divider lowered below the running count
   // produces a tick immediately instead of wrapping through 65536.
   assign tick_o = clk__enable && (divider_i != 16'd0) && (tick_cnt_q >= divider_i);

   always_comb begin
      tick_cnt_d = tick_cnt_q + 16'd1;
      if (divider_i == 16'd0 || tick_o) begin
         tick_cnt_d = 16'd0;
      end
      // Filtered clock follows the pin only once two successive tick
      // samples agree, so a single-tick glitch is rejected.
      filt_clk_d = filt_clk_q;
      if (tick_o && (sync_q.clk == clk_smp_q)) begin
         filt_clk_d = sync_q.clk;
      end
   end

   assign falling_edge_o = filt_clk_q & ~filt_clk_d;
   assign sampled_data_o = sync_q.data;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         meta_q     <= '1;
         sync_q     <= '1;
         tick_cnt_q <= 16'd0;
         clk_smp_q  <= 1'b1;
         filt_clk_q <= 1'b1;
      end else if (clk__enable) begin
         meta_q     <= pins_i;
         sync_q     <= meta_q;
         tick_cnt_q <= tick_cnt_d;
         filt_clk_q <= filt_clk_d;
         if (tick_o) begin
            clk_smp_q <= sync_q.clk;
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/ps2_host_receiver.sv
`default_nettype none
// ============================================================================
//  Module      : ps2_host_receiver
//  Description : PS/2 host receive front end. Deserialises 11-bit device
//                frames, checks start/stop/odd parity, aborts stalled frames
//                and emits one-cycle receive strobes. After any error the
//                PS/2 clock is held low to make the device resend.
//  Ports       : clk, clk__enable, reset (async, active high), divider
//                ps2_in__clk/ps2_in__data   - raw PS/2 pins
//                ps2_out__clk/ps2_out__data - 1 = release, 0 = pull low
//                ps2_rx_data__*             - receive strobe and payload
//  Revision    : 1.0 - initial release
// ============================================================================
module ps2_host_receiver
   import ps2_host_receiver_pkg::*;
#(
   parameter int TIMEOUT_TICKS = TIMEOUT_TICKS_DEFAULT,
   parameter int INHIBIT_TICKS = INHIBIT_TICKS_DEFAULT
) (
   input  logic        clk,
   input  logic        clk__enable,
   input  logic        reset,
   input  logic [15:0] divider,
   input  logic        ps2_in__clk,
   input  logic        ps2_in__data,
   output logic        ps2_out__clk,
   output logic        ps2_out__data,
   output logic        ps2_rx_data__valid,
   output logic [7:0]  ps2_rx_data__data,
   output logic        ps2_rx_data__parity_error,
   output logic        ps2_rx_data__protocol_error,
   output logic        ps2_rx_data__timeout
);

   logic w_tick;
   logic w_fall;
   logic w_data;

   ps2_clock_sampler u_sampler (
      .clk            (clk),
      .clk__enable    (clk__enable),
      .reset          (reset),
      .divider_i      (divider),
      .pins_i         ('{clk: ps2_in__clk, data: ps2_in__data}),
      .tick_o         (w_tick),
      .falling_edge_o (w_fall),
      .sampled_data_o (w_data)
   );

   t_ps2_rx_fsm  state_q, state_d;
   logic [7:0]   shift_q, shift_d;
   logic [2:0]   bit_cnt_q, bit_cnt_d;
   logic         perr_q, perr_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;   // ticks since last edge / ticks inhibited
   t_ps2_rx_data rx_q, rx_d;

   always_comb begin
      state_d   = state_q;
      shift_d   = shift_q;
      bit_cnt_d = bit_cnt_q;
      perr_d    = perr_q;
      cnt_d     = cnt_q;
      rx_d      = '0;

      if (divider == 16'd0) begin
         state_d   = ST_IDLE;
         bit_cnt_d = 3'd0;
         cnt_d     = '0;
      end else if (w_tick) begin
         unique case (state_q)
            ST_IDLE: begin
               if (w_fall) begin
                  cnt_d = '0;
                  if (!w_data) begin
                     state_d   = ST_DATA;
                     shift_d   = 8'd0;
                     bit_cnt_d = 3'd0;
                  end else begin
                     rx_d.valid          = 1'b1;
                     rx_d.protocol_error = 1'b1;
                     state_d             = ST_INHIBIT;
                  end
               end
            end
            ST_DATA, ST_PARITY, ST_STOP: begin
               // Edge is tested first so it wins over a same-tick timeout.
               if (w_fall) begin
                  cnt_d = '0;
                  case (state_q)
                     ST_DATA: begin
                        shift_d   = {w_data, shift_q[7:1]};
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                           state_d = ST_PARITY;
                        end
                     end
                     ST_PARITY: begin
                        perr_d  = ~(^shift_q ^ w_data);
                        state_d = ST_STOP;
                     end
                     default: begin
                        rx_d.valid          = 1'b1;
                        rx_d.data           = shift_q;
                        rx_d.parity_error   = perr_q;
                        rx_d.protocol_error = ~w_data;
                        state_d = (perr_q || !w_data) ? ST_INHIBIT : ST_IDLE;
                     end
                  endcase
               end else if (cnt_q == CNT_W'(TIMEOUT_TICKS - 1)) begin
                  rx_d.valid   = 1'b1;
                  rx_d.data    = shift_q;
                  rx_d.timeout = 1'b1;
                  state_d      = ST_INHIBIT;
                  cnt_d        = '0;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
            ST_INHIBIT: begin
               if (cnt_q == CNT_W'(INHIBIT_TICKS - 1)) begin
                  state_d = ST_IDLE;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
            default: begin
               state_d = ST_IDLE;
               cnt_d   = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         shift_q   <= 8'd0;
         bit_cnt_q <= 3'd0;
         perr_q    <= 1'b0;
         cnt_q     <= '0;
         rx_q      <= '0;
      end else if (clk__enable) begin
         state_q   <= state_d;
         shift_q   <= shift_d;
         bit_cnt_q <= bit_cnt_d;
         perr_q    <= perr_d;
         cnt_q     <= cnt_d;
         rx_q      <= rx_d;
      end
   end

   assign ps2_out__clk                = (state_q != ST_INHIBIT);
   assign ps2_out__data               = 1'b1;
   assign ps2_rx_data__valid          = rx_q.valid;
   assign ps2_rx_data__data           = rx_q.data;
   assign ps2_rx_data__parity_error   = rx_q.parity_error;
   assign ps2_rx_data__protocol_error = rx_q.protocol_error;
   assign ps2_rx_data__timeout        = rx_q.timeout;

endmodule
`default_nettype wire
